// File: rtl/branch_sequencer.sv
// Multicycle branch-resolution controller: captures a branch request, resolves it in a
// dedicated EVAL cycle and commits a registered next-PC. Optional statistics: BRANCH_SEQ_STATS_EN.
module branch_sequencer #(
    parameter int WORD_SIZE = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           branch_type,
    input  logic [WORD_SIZE-1:0] reg_a,
    input  logic [WORD_SIZE-1:0] reg_b,
    input  logic [WORD_SIZE-1:0] pc_plus4,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic                 busy,
    output logic                 done,
    output logic                 taken,
    output logic                 pc_write,
    output logic [WORD_SIZE-1:0] next_pc,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] taken_count,
    output logic [CNT_WIDTH-1:0] not_taken_count,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVAL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t               state;
    logic [2:0]           type_q;
    logic [WORD_SIZE-1:0] a_q;
    logic [WORD_SIZE-1:0] b_q;
    logic [WORD_SIZE-1:0] pc4_q;
    logic [WORD_SIZE-1:0] target_q;
    logic                 cond;
    logic                 cond_illegal;

    assign state_dbg = state;

    // Resolution works only on the captured copies, never on the live inputs.
    always_comb begin
        cond         = 1'b0;
        cond_illegal = 1'b0;
        case (type_q)
            3'b000:  cond = 1'b0;
            3'b001:  cond = (a_q == b_q);
            3'b010:  cond = (a_q != b_q);
            3'b011:  cond = ($signed(a_q) <  $signed(b_q));
            3'b100:  cond = ($signed(a_q) <= $signed(b_q));
            default: cond_illegal = 1'b1;
        endcase
    end

    // Handshake: start is accepted only in IDLE (busy low); each accepted start yields
    // exactly one done pulse two cycles later, and requests seen while busy are dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            taken    <= 1'b0;
            pc_write <= 1'b0;
            illegal  <= 1'b0;
            next_pc  <= '0;
            type_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            pc4_q    <= '0;
            target_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    pc_write <= 1'b0;
                    illegal  <= 1'b0;
                    if (start) begin
                        type_q   <= branch_type;
                        a_q      <= reg_a;
                        b_q      <= reg_b;
                        pc4_q    <= pc_plus4;
                        target_q <= branch_target;
                        busy     <= 1'b1;
                        state    <= EVAL;
                    end
                end
                EVAL: begin
                    taken    <= cond;
                    next_pc  <= cond ? target_q : pc4_q;
                    pc_write <= cond;
                    illegal  <= cond_illegal;
                    done     <= 1'b1;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    done     <= 1'b0;
                    pc_write <= 1'b0;
                    illegal  <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef BRANCH_SEQ_STATS_EN
    // Saturating counters updated on the same edge that registers the decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            taken_count     <= '0;
            not_taken_count <= '0;
        end else if (state == EVAL) begin
            if (cond) begin
                if (taken_count != '1)
                    taken_count <= taken_count + CNT_WIDTH'(1);
            end else begin
                if (not_taken_count != '1)
                    not_taken_count <= not_taken_count + CNT_WIDTH'(1);
            end
        end
    end
`else
    assign taken_count     = '0;
    assign not_taken_count = '0;
`endif

endmodule
